axi4_slave_mem: RTL and testbench
=================================

Name: axi4_slave_mem

Overview:
- Synthesizable AXI4 slave memory that terminates the master BFM's write/read single and burst transactions in the simulation bench.
- Provides DEPTH words of byte-strobed storage.
- Independent write and read engines, one outstanding transaction each, INCR bursts up to 256 beats.
- Sits directly downstream of the master BFM; its contents are checked through BFM read-back.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, data width in bits; power of 2, >=8; every beat is full-width (size signals not used)
ID_W, 18, AXI ID width
DEPTH, 1024, memory depth in DATA_W words; power of 2

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
awid  in  ID_W  write ID
awaddr  in  ADDR_W  write start byte address
awlen  in  8  write beats minus 1
awburst  in  2  burst type
awvalid/awready  in/out  1  AW handshake
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte enables
wlast  in  1  final write beat
wvalid/wready  in/out  1  W handshake
bid  out  ID_W  response ID
bresp  out  2  write response
bvalid/bready  out/in  1  B handshake
arid  in  ID_W  read ID
araddr  in  ADDR_W  read start byte address
arlen  in  8  read beats minus 1
arburst  in  2  burst type
arvalid/arready  in/out  1  AR handshake
rid  out  ID_W  read ID
rdata  out  DATA_W  read data
rresp  out  2  read response
rlast  out  1  final read beat
rvalid/rready  out/in  1  R handshake

Behaviour:
- Reset (aresetn=0 at a rising aclk edge): both FSMs go to IDLE. awready=1, arready=1. wready, bvalid, rvalid, rlast=0. bresp, rresp, bid, rid, rdata=0. Memory contents are not reset. Reset mid-burst abandons the burst with no response.
- Word index = (addr >> log2(DATA_W/8)). Low address bits are ignored. A beat is out of range when its index >= DEPTH.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. On awvalid&awready, latch id, index, len and bad=(awburst!=INCR). Go to W_DATA; awready drops next cycle.
  - W_DATA: wready=1. Each wvalid&wready writes the wstrb-enabled bytes of wdata to mem[index], but only if !bad and the index is in range. Then index+1 and beat counter+1.
  - Each beat sets err if it was out of range, or if wlast != (counter==len).
  - On the beat with counter==len, go to W_RESP (wready=0). W beats arriving before AW are not accepted.
  - W_RESP: bvalid=1, bid=latched id, bresp=SLVERR(2'b10) if bad|err, else OKAY. Hold until bready. Return to W_IDLE the cycle after the handshake.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. On the AR handshake, latch id, index, len and bad.
  - rvalid=1 from the next cycle: first-beat latency is 1 cycle after the AR handshake.
  - R_DATA: rdata=mem[index] (0 if out of range or bad), rid=latched id, rresp=SLVERR if bad or index out of range, else OKAY, rlast=(counter==len).
  - rdata/rresp/rlast stay stable while rvalid&!rready.
  - On each rvalid&rready, index+1 and counter+1. After the last beat, rvalid=0 and FSM returns to R_IDLE (arready=1 next cycle).
- Channel independence: both engines run concurrently. A write handshaked in cycle N is visible to a read beat presented in cycle N+1 or later.
- Burst length: len=0 is a single beat; len=255 is 256 beats. The index counter is ADDR_W wide and does not wrap inside memory.

Test Plan:
- Write 0xDEADBEEF to addr 0x10 with wstrb 4'hF, then read 0x10 -> bresp OKAY; read returns 0xDEADBEEF with rlast=1 and rresp OKAY.
- Write 0xAABBCCDD to addr 0x20 with wstrb 4'h5 over pre-existing 0x11223344 -> read back 0x11BB33DD.
- 8-beat INCR write from 0x0 of data i*0x01010101, then 8-beat read with rready toggled every other cycle -> beats match in order; rlast only on beat 7; rdata held stable while stalled.
- Write at index DEPTH-2 with awlen=3 -> bresp SLVERR; words DEPTH-2 and DEPTH-1 are written. Matching read -> beats 2 and 3 return rresp SLVERR with rdata 0.
- awburst=WRAP, single beat -> bresp SLVERR and memory unchanged. Write with wlast asserted on beat 0 of awlen=1 -> SLVERR.
- Drop aresetn for one cycle mid 16-beat read -> rvalid=0 and arready=1 after reset. A new single read completes normally.

Source files
------------

// File: rtl/axi4_slave_mem_if.sv
// AXI4 bus bundle between a master BFM and the axi4_slave_mem target.
// The slave modport is the memory's view, and the master modport is the driver's view.
interface axi4_slave_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 18
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awid, awaddr, awlen, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory: DEPTH full-width words, byte strobes, INCR bursts up to 256 beats.
// The write and read engines are independent, and each engine holds one outstanding transaction.
module axi4_slave_mem #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 18,
  parameter int DEPTH  = 1024
) (
  input  logic             aclk,
  input  logic             aresetn,
  axi4_slave_mem_if.slave  s_axi
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // ---------------------------------------------------------------- write engine
  w_state_e          w_state_q, w_state_d;
  logic [ID_W-1:0]   w_id_q, w_id_d;
  logic [ADDR_W-1:0] w_idx_q, w_idx_d;
  logic [7:0]        w_len_q, w_len_d;
  logic [7:0]        w_cnt_q, w_cnt_d;
  logic              w_bad_q, w_bad_d;
  logic              w_err_q, w_err_d;
  logic              w_in_range, w_last_beat, mem_we;
  logic [DATA_W-1:0] mem_wdata;

  // NOTE: combinational blocks use blocking '=' and give every output a default first, so no latch is inferred.
  always_comb begin
    w_state_d   = w_state_q;
    w_id_d      = w_id_q;
    w_idx_d     = w_idx_q;
    w_len_d     = w_len_q;
    w_cnt_d     = w_cnt_q;
    w_bad_d     = w_bad_q;
    w_err_d     = w_err_q;
    mem_we      = 1'b0;
    w_in_range  = (w_idx_q < ADDR_W'(DEPTH));
    w_last_beat = (w_cnt_q == w_len_q);
    mem_wdata   = mem_q[w_idx_q[IDX_W-1:0]];
    for (int b = 0; b < STRB_W; b++) begin
      if (s_axi.wstrb[b]) mem_wdata[b*8 +: 8] = s_axi.wdata[b*8 +: 8];
    end

    unique case (w_state_q)
      W_IDLE: begin
        if (s_axi.awvalid) begin
          w_id_d    = s_axi.awid;
          w_idx_d   = s_axi.awaddr >> OFF_W;
          w_len_d   = s_axi.awlen;
          w_cnt_d   = 8'd0;
          w_bad_d   = (s_axi.awburst != BURST_INCR);
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi.wvalid) begin
          // Out-of-range or non-INCR beats are still consumed so the burst completes.
          mem_we  = !w_bad_q && w_in_range && aresetn;
          w_idx_d = w_idx_q + ADDR_W'(1);
          w_cnt_d = w_cnt_q + 8'd1;
          if (!w_in_range || (s_axi.wlast != w_last_beat)) w_err_d = 1'b1;
          if (w_last_beat) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_bad_q   <= 1'b0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_bad_q   <= w_bad_d;
      w_err_q   <= w_err_d;
    end
  end

  // NOTE: storage has no reset branch; contents are undefined until written, and a reset would prevent RAM mapping.
  always_ff @(posedge aclk) begin
    if (mem_we) mem_q[w_idx_q[IDX_W-1:0]] <= mem_wdata;
  end

  assign s_axi.awready = (w_state_q == W_IDLE);
  assign s_axi.wready  = (w_state_q == W_DATA);
  assign s_axi.bvalid  = (w_state_q == W_RESP);
  assign s_axi.bid     = w_id_q;
  assign s_axi.bresp   = ((w_state_q == W_RESP) && (w_bad_q || w_err_q)) ? RESP_SLVERR : RESP_OKAY;

  // ---------------------------------------------------------------- read engine
  r_state_e          r_state_q, r_state_d;
  logic [ID_W-1:0]   r_id_q, r_id_d;
  logic [ADDR_W-1:0] r_idx_q, r_idx_d;
  logic [7:0]        r_len_q, r_len_d;
  logic [7:0]        r_cnt_q, r_cnt_d;
  logic              r_bad_q, r_bad_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rlast_q, rlast_d;
  logic [ADDR_W-1:0] rd_idx;
  logic              rd_bad, rd_load, rd_in_range;
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_bad_d   = r_bad_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    rd_idx    = r_idx_q + ADDR_W'(1);
    rd_bad    = r_bad_q;
    rd_load   = 1'b0;

    unique case (r_state_q)
      R_IDLE: begin
        if (s_axi.arvalid) begin
          rd_idx    = s_axi.araddr >> OFF_W;
          rd_bad    = (s_axi.arburst != BURST_INCR);
          rd_load   = 1'b1;
          r_id_d    = s_axi.arid;
          r_idx_d   = rd_idx;
          r_len_d   = s_axi.arlen;
          r_cnt_d   = 8'd0;
          r_bad_d   = rd_bad;
          rlast_d   = (s_axi.arlen == 8'd0);
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi.rready) begin
          if (rlast_q) begin
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            rd_load = 1'b1;
            r_idx_d = rd_idx;
            r_cnt_d = r_cnt_q + 8'd1;
            rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    // Forward a same-cycle write so the next presented beat already sees it.
    rd_in_range = (rd_idx < ADDR_W'(DEPTH));
    rd_word     = mem_q[rd_idx[IDX_W-1:0]];
    if (mem_we && (w_idx_q == rd_idx)) rd_word = mem_wdata;

    if (rd_load) begin
      rdata_d = (rd_bad || !rd_in_range) ? '0 : rd_word;
      rresp_d = (rd_bad || !rd_in_range) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_bad_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_bad_q   <= r_bad_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  assign s_axi.arready = (r_state_q == R_IDLE);
  assign s_axi.rvalid  = (r_state_q == R_DATA);
  assign s_axi.rid     = r_id_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rlast   = rlast_q;
endmodule

// File: tb/tb_axi4_slave_mem.sv
// Randomised bench for axi4_slave_mem: bus tasks drive AXI traffic and compare against a word-array model.
// The model applies byte-strobe, range and burst-type rules directly per beat.
module tb_axi4_slave_mem;
  localparam int DEPTH = 1024;
  localparam int TMO   = 3000;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi4_slave_mem_if #(.ADDR_W(32), .DATA_W(32), .ID_W(18)) bus ();

  axi4_slave_mem #(.ADDR_W(32), .DATA_W(32), .ID_W(18), .DEPTH(DEPTH)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axi   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] wd_q [$];
  logic [3:0]  ws_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_write(input longint idx, input logic [31:0] d, input logic [3:0] s);
    if (idx < DEPTH) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model_mem[int'(idx)][b*8 +: 8] = d[b*8 +: 8];
      end
    end
  endfunction

  task automatic load_beats(input int beats, input bit rand_strb);
    wd_q.delete();
    ws_q.delete();
    for (int i = 0; i < beats; i++) begin
      wd_q.push_back($urandom);
      ws_q.push_back(rand_strb ? 4'($urandom) : 4'hF);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input int bad_last, input string tag);
    logic [17:0] id;
    bit          bad, err;
    int          n;
    longint      idx;
    id  = 18'($urandom);
    bad = (burst != 2'b01);
    err = 1'b0;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awburst = burst; bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < TMO) begin @(posedge aclk); #1; n++; end
    check({tag, "_aw_hs"}, n < TMO, 1'b1);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      idx = longint'(addr >> 2) + i;
      bus.wdata  = wd_q[i];
      bus.wstrb  = ws_q[i];
      bus.wlast  = (i == int'(len)) != (i == bad_last);
      bus.wvalid = 1'b1;
      n = 0;
      while (!bus.wready && n < TMO) begin @(posedge aclk); #1; n++; end
      if (n >= TMO) check({tag, "_w_hs"}, 1'b0, 1'b1);
      @(posedge aclk); #1;
      if (idx >= DEPTH || i == bad_last) err = 1'b1;
      if (!bad) model_write(idx, wd_q[i], ws_q[i]);
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    bus.bready = 1'b1;
    n = 0;
    while (!bus.bvalid && n < TMO) begin @(posedge aclk); #1; n++; end
    check({tag, "_bresp"}, bus.bresp, (bad || err) ? 2'b10 : 2'b00);
    check({tag, "_bid"}, bus.bid, id);
    @(posedge aclk); #1;
    bus.bready = 1'b0;
    check({tag, "_awready_after_b"}, {bus.awready, bus.bvalid}, 2'b10);
  endtask

  // mode 0: rready always high, 1: toggles every cycle, 2: random
  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input int mode, input int abort_after, input string tag,
                          output logic [31:0] last_data);
    logic [17:0] id;
    int          n, beat;
    longint      idx;
    logic [31:0] ed;
    logic [1:0]  er;
    bit          take;
    id = 18'($urandom);
    last_data = '0;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arburst = burst; bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < TMO) begin @(posedge aclk); #1; n++; end
    check({tag, "_ar_hs"}, n < TMO, 1'b1);
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    check({tag, "_first_latency"}, bus.rvalid, 1'b1);
    beat = 0;
    n = 0;
    while (beat <= int'(len) && n < TMO) begin
      if (abort_after >= 0 && beat == abort_after) break;
      case (mode)
        0:       bus.rready = 1'b1;
        1:       bus.rready = (n % 2 == 0);
        default: bus.rready = 1'($urandom_range(0, 1));
      endcase
      if (bus.rvalid) begin
        idx = longint'(addr >> 2) + beat;
        if (burst != 2'b01 || idx >= DEPTH) begin ed = '0; er = 2'b10; end
        else begin ed = model_mem[int'(idx)]; er = 2'b00; end
        check({tag, "_rdata"}, bus.rdata, ed);
        check({tag, "_rresp"}, bus.rresp, er);
        check({tag, "_rlast"}, bus.rlast, beat == int'(len));
        check({tag, "_rid"}, bus.rid, id);
        last_data = bus.rdata;
      end
      take = bus.rvalid && bus.rready;
      @(posedge aclk); #1;
      n++;
      if (take) beat++;
    end
    if (abort_after < 0) begin
      check({tag, "_r_complete"}, beat == int'(len) + 1, 1'b1);
      bus.rready = 1'b0;
      check({tag, "_r_idle"}, {bus.rvalid, bus.arready}, 2'b01);
    end
  endtask

  logic [31:0] rd;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    repeat (3) @(posedge aclk);
    #1;
    check("rst_ready", {bus.awready, bus.arready}, 2'b11);
    check("rst_valid", {bus.wready, bus.bvalid, bus.rvalid, bus.rlast}, 4'b0000);
    check("rst_resp", {bus.bresp, bus.rresp}, 4'b0000);
    check("rst_ids", {bus.bid, bus.rid}, 36'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Fill the whole memory with 256-beat bursts so the model is fully defined.
    for (int k = 0; k < DEPTH / 256; k++) begin
      load_beats(256, 1'b0);
      axi_write(32'(k * 1024), 8'd255, 2'b01, -1, "fill");
    end
    axi_read(32'h0, 8'd255, 2'b01, 2, -1, "fill_rd", rd);

    load_beats(1, 1'b0);
    wd_q[0] = 32'hDEADBEEF;
    axi_write(32'h10, 8'd0, 2'b01, -1, "single_wr");
    axi_read(32'h10, 8'd0, 2'b01, 0, -1, "single_rd", rd);
    check("single_value", rd, 32'hDEADBEEF);

    load_beats(1, 1'b0);
    wd_q[0] = 32'h11223344;
    axi_write(32'h20, 8'd0, 2'b01, -1, "pre_wr");
    wd_q[0] = 32'hAABBCCDD;
    ws_q[0] = 4'h5;
    axi_write(32'h20, 8'd0, 2'b01, -1, "strb_wr");
    axi_read(32'h20, 8'd0, 2'b01, 0, -1, "strb_rd", rd);
    check("strb_merge", rd, 32'h11BB33DD);

    load_beats(8, 1'b0);
    for (int i = 0; i < 8; i++) wd_q[i] = 32'(i) * 32'h01010101;
    axi_write(32'h0, 8'd7, 2'b01, -1, "burst8_wr");
    axi_read(32'h0, 8'd7, 2'b01, 1, -1, "burst8_rd", rd);
    check("burst8_last", rd, 32'h07070707);

    load_beats(4, 1'b0);
    axi_write(32'((DEPTH - 2) * 4), 8'd3, 2'b01, -1, "edge_wr");
    axi_read(32'((DEPTH - 2) * 4), 8'd3, 2'b01, 2, -1, "edge_rd", rd);

    load_beats(1, 1'b0);
    axi_write(32'h40, 8'd0, 2'b10, -1, "wrap_wr");
    axi_read(32'h40, 8'd0, 2'b01, 0, -1, "wrap_chk", rd);
    axi_read(32'h40, 8'd0, 2'b10, 0, -1, "wrap_rd", rd);

    load_beats(2, 1'b0);
    axi_write(32'h80, 8'd1, 2'b01, 0, "early_wlast");
    axi_read(32'h80, 8'd1, 2'b01, 0, -1, "early_wlast_rd", rd);

    // Reset in the middle of a 16-beat read: the burst is abandoned.
    axi_read(32'h100, 8'd15, 2'b01, 0, 3, "abort_rd", rd);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    bus.rready = 1'b0;
    check("abort_state", {bus.rvalid, bus.rlast, bus.arready, bus.awready}, 4'b0011);
    axi_read(32'h20, 8'd0, 2'b01, 0, -1, "post_rst_rd", rd);
    check("post_rst_value", rd, 32'h11BB33DD);

    for (int t = 0; t < 40; t++) begin
      longint     idx;
      logic [7:0] len;
      logic [1:0] burst;
      logic [31:0] addr;
      int         bad_last;
      idx   = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(DEPTH - 20, DEPTH + 4))
                                          : longint'($urandom_range(0, DEPTH - 1));
      addr  = 32'(idx * 4) | 32'($urandom_range(0, 3));
      len   = 8'($urandom_range(0, 15));
      burst = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      bad_last = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, int'(len))) : -1;
      if ($urandom_range(0, 1) == 1) begin
        load_beats(int'(len) + 1, 1'b1);
        axi_write(addr, len, burst, bad_last, "rnd_wr");
      end else begin
        axi_read(addr, len, burst, 2, -1, "rnd_rd", rd);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
